dm_arbiter: RTL
===============

Name: dm_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the pipeline MEM stage, port 1 is an auxiliary master such as a loader or debug port.
- Arbitrates round-robin and issues at most one access per cycle.
- Converts byte-address plus size into a word address, byte-lane write enables and lane-replicated write data.
- Returns the raw read word one cycle after issue, tagged to the owning requester.

Parameters:
ADDR_W, 12, word-address width of the memory (4096 words)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
m0_req  in  1  port 0 request, held until granted
m0_we  in  1  port 0 write (1) / read (0)
m0_size  in  2  00 byte, 01 half, 10 word; 11 reserved
m0_addr  in  ADDR_W+2  port 0 byte address
m0_wdata  in  32  port 0 store data, right-aligned
m0_gnt  out  1  port 0 access issued this cycle
m0_rvalid  out  1  port 0 read data valid
m0_err  out  1  port 0 misaligned or reserved-size pulse
m1_req, m1_we, m1_size, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_err: same as port 0, for port 1
rdata  out  32  read word returned to the rvalid owner
mem_en  out  1  memory access strobe
mem_be  out  4  byte write enables; 0000 on reads
mem_addr  out  ADDR_W  word address = byte address[ADDR_W+1:2]
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  synchronous-read data, valid the cycle after mem_en

Behaviour:
- Reset values:
  - m*_gnt=0, m*_rvalid=0, m*_err=0, mem_en=0, mem_be=0.
  - last_owner=1, so port 0 wins the first tie.
  - Pending-read register cleared; rdata=0.
- Reset overrides everything. A read issued in the cycle before reset yields no rvalid after reset.
- Arbitration is combinational in the request cycle:
  - Only one port requesting: that port is selected.
  - Both requesting: the port not equal to last_owner is selected.
  - last_owner updates at posedge to the port that was granted. Error cycles do not count as grants.
- Alignment check on the selected port:
  - Error if size=11, or half with addr[0]=1, or word with addr[1:0]!=0.
  - On error: m*_err=1 and m*_gnt=1 for that cycle (the request is consumed), mem_en=0, no rvalid follows, last_owner unchanged.
- Issue (legal access): m*_gnt=1, mem_en=1, mem_addr=addr[ADDR_W+1:2].
- Writes:
  - byte: mem_be = 0001<<addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
  - half: mem_be = 0011 (addr[1]=0) or 1100 (addr[1]=1); mem_wdata = {2{wdata[15:0]}}.
  - word: mem_be = 1111; mem_wdata = wdata.
- Reads:
  - mem_be=0000. The pending register records the owner.
  - Next cycle: owner's m*_rvalid=1 for exactly one cycle, and rdata=mem_rdata. The full word is returned; sign/zero extension is done by the requester.
  - rdata holds its last value when no rvalid is asserted.
- Throughput and pipelining:
  - One access per cycle. Back-to-back issues are allowed: a read issued in cycle N returns in N+1 while a new access issues in N+1.
  - A write issued in cycle N and a read of the same word in N+1 return the written data. Memory write-before-read ordering is guaranteed by posedge capture.
- Requests must stay stable until gnt. A requester dropping req before gnt is legal; nothing issues for it.
- The non-selected port sees gnt=0 and retries next cycle. Maximum wait with both requesting continuously is 1 cycle.
- All outputs other than rvalid, err-free pending state and rdata are combinational from inputs plus last_owner.

Test Plan:
- Reset, then m0 word write addr 0x0010 data 0x12345678 -> mem_en=1, mem_be=1111, mem_addr=4; next cycle m0 word read addr 0x0010 -> m0_rvalid=1 one cycle later, rdata=0x12345678.
- m0 byte write addr 0x0013 data 0x000000AB -> mem_be=1000, mem_wdata=0xABABABAB; m1 half write addr 0x0022 data 0xBEEF -> mem_be=1100, mem_wdata=0xBEEFBEEF.
- Both ports request reads continuously for 4 cycles after reset -> grants m0,m1,m0,m1; rvalid alternates m0,m1,m0,m1 one cycle behind, each rdata matching its address.
- m1 word read addr 0x0006 -> m1_err=1, m1_gnt=1, mem_en=0, no m1_rvalid; m0 half addr 0x0001 -> m0_err=1; m0 size=11 -> m0_err=1; in each case last_owner unchanged.
- Issue m0 read, assert reset the next cycle -> m0_rvalid stays 0, all outputs at reset values; the first tie after reset is granted to m0.

Source files
------------

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the MEM stage (port 0)
// and an auxiliary master (port 1). It also does byte-lane steering and tags read returns.
module dm_arbiter #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [1:0]        m0_size,
    input  logic [ADDR_W+1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [1:0]        m1_size,
    input  logic [ADDR_W+1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic              m1_err,
    output logic [31:0]       rdata,
    output logic              mem_en,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    logic              sel, go, mis, issue, we;
    logic [1:0]        size;
    logic [ADDR_W+1:0] addr;
    logic [31:0]       wdata, lane_wdata;
    logic [3:0]        lane_be;
    logic              last_owner, pend_vld, pend_owner;
    logic [31:0]       rdata_q;

    always_comb begin
        // On a tie the port that did not win last time goes first.
        sel   = m1_req & (~m0_req | ~last_owner);
        go    = (m0_req | m1_req) & ~reset;
        we    = sel ? m1_we    : m0_we;
        size  = sel ? m1_size  : m0_size;
        addr  = sel ? m1_addr  : m0_addr;
        wdata = sel ? m1_wdata : m0_wdata;
        mis   = (size == 2'b11) | ((size == 2'b01) & addr[0]) |
                ((size == 2'b10) & (addr[1:0] != 2'b00));
        issue = go & ~mis;
        case (size)
            2'b00: begin
                lane_be    = 4'b0001 << addr[1:0];
                lane_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                lane_be    = addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata[15:0]}};
            end
            default: begin
                lane_be    = 4'b1111;
                lane_wdata = wdata;
            end
        endcase
    end

    assign m0_gnt    = go & ~sel;
    assign m1_gnt    = go & sel;
    assign m0_err    = go & ~sel & mis;
    assign m1_err    = go & sel & mis;
    assign mem_en    = issue;
    assign mem_be    = (issue & we) ? lane_be : 4'b0000;
    assign mem_addr  = addr[ADDR_W+1:2];
    assign mem_wdata = lane_wdata;

    // Reads return in the cycle after issue; reset suppresses any return still in flight.
    assign m0_rvalid = pend_vld & ~reset & ~pend_owner;
    assign m1_rvalid = pend_vld & ~reset & pend_owner;
    assign rdata     = reset ? 32'h0 : (pend_vld ? mem_rdata : rdata_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner <= 1'b1;
            pend_vld   <= 1'b0;
            pend_owner <= 1'b0;
            rdata_q    <= 32'h0;
        end else begin
            if (issue)
                last_owner <= sel;
            pend_vld   <= issue & ~we;
            pend_owner <= sel;
            if (pend_vld)
                rdata_q <= mem_rdata;
        end
    end
endmodule
